// File: rtl/tank_sensor_conditioner_pkg.sv
// Shared constants and helpers for the tank sensor conditioner.
// Holds nivel codes, switch indices and sensor-pattern helpers.
package tank_sensor_conditioner_pkg;

  localparam logic [2:0] NIVEL_FULL = 3'b000;
  localparam logic [2:0] NIVEL_MED  = 3'b001;
  localparam logic [2:0] NIVEL_LOW  = 3'b011;
  localparam logic [2:0] NIVEL_CRIT = 3'b111;

  localparam int SW_ASP = 0;
  localparam int SW_GOT = 1;
  localparam int SW_ADB = 2;

  // A float can only be wet if every float below it is wet.
  function automatic logic sens_valid(input logic [2:0] s);
    logic v;
    case (s)
      3'b111, 3'b011,
      3'b001, 3'b000: v = 1'b1;
      default:        v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] sens_encode(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      3'b111:  n = NIVEL_FULL;
      3'b011:  n = NIVEL_MED;
      3'b001:  n = NIVEL_LOW;
      default: n = NIVEL_CRIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tank_sensor_conditioner_debouncer.sv
// input_debouncer: 1-bit tick-gated counting debouncer.
// Ports: clock, reset (sync, active-low), tick, raw in; db out.
module input_debouncer #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_TICKS);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          db_q, db_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (tick) begin
      if (raw != db_q) begin
        if (cnt_inc == LIM) begin
          db_d  = ~db_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/tank_sensor_conditioner.sv
// Tank sensor conditioner: debounce, validate and encode floats/switches.
// Ports: clock, reset(sync low), tick, sens_raw[3], sw_raw[3], err_clr ->
//   nivel[3], erro, sw_db[3], level_chg. Macro: SENSOR_ERR_AUTOCLR_EN.
module tank_sensor_conditioner
  import tank_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int ERR_PERSIST    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] sens_raw,
  input  logic [2:0] sw_raw,
  input  logic       err_clr,
  output logic [2:0] nivel,
  output logic       erro,
  output logic [2:0] sw_db,
  output logic       level_chg
);

  localparam int FW = $clog2(ERR_PERSIST + 1);
  localparam logic [FW-1:0] EP = FW'(ERR_PERSIST);

  logic [5:0] raw_all;
  logic [5:0] db_all;
  logic [2:0] sens_db;
  logic       vld;

  assign raw_all = {sw_raw, sens_raw};

  for (genvar i = 0; i < 6; i++) begin : g_db
    input_debouncer #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .tick (tick),
      .raw  (raw_all[i]),
      .db   (db_all[i])
    );
  end

  assign sens_db       = db_all[2:0];
  assign sw_db[SW_ASP] = db_all[3+SW_ASP];
  assign sw_db[SW_GOT] = db_all[3+SW_GOT];
  assign sw_db[SW_ADB] = db_all[3+SW_ADB];
  assign vld           = sens_valid(sens_db);

  logic [2:0]    nivel_q, nivel_d;
  logic          chg_q, chg_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          erro_q, erro_d;
  logic          auto_clr;

`ifdef SENSOR_ERR_AUTOCLR_EN
  logic [FW-1:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q;
    if (tick) begin
      if (vld) begin
        if (rcnt_q != EP) rcnt_d = rcnt_q + 1'b1;
      end else begin
        rcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end

  assign auto_clr = (rcnt_q == EP);
`else
  assign auto_clr = 1'b0;
`endif

  always_comb begin
    fcnt_d = fcnt_q;
    if (tick) begin
      if (!vld) begin
        if (fcnt_q != EP) fcnt_d = fcnt_q + 1'b1;
      end else begin
        fcnt_d = '0;
      end
    end
  end

  // A saturated fault count keeps re-asserting, so it beats any clear.
  always_comb begin
    erro_d = erro_q;
    if (fcnt_q == EP)            erro_d = 1'b1;
    else if (err_clr || auto_clr) erro_d = 1'b0;
  end

  // Invalid patterns keep the last level; a fault overrides to critical.
  always_comb begin
    nivel_d = nivel_q;
    if (vld)    nivel_d = sens_encode(sens_db);
    if (erro_q) nivel_d = NIVEL_CRIT;
    chg_d = (nivel_d != nivel_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      nivel_q <= NIVEL_CRIT;
      chg_q   <= 1'b0;
      fcnt_q  <= '0;
      erro_q  <= 1'b0;
    end else begin
      nivel_q <= nivel_d;
      chg_q   <= chg_d;
      fcnt_q  <= fcnt_d;
      erro_q  <= erro_d;
    end
  end

  assign nivel     = nivel_q;
  assign level_chg = chg_q;
  assign erro      = erro_q;

endmodule

// File: doc/tank_sensor_conditioner.md
Name: tank_sensor_conditioner

Overview:
- Input-conditioning stage directly upstream of the irrigation controller top level.
- Debounces the three raw tank float sensors and the three operator switches (asp, got, adb).
- Validates the sensor thermometer code and encodes it into the 3-bit nivel code consumed by the level/cleaning/MEF logic.
- Raises the erro flag on a persistent implausible sensor pattern; all sampling is gated by a divided-clock tick.

Parameters:
- DEBOUNCE_TICKS, 4, consecutive ticks a raw input must differ from its debounced value before the debounced value flips (>=1)
- ERR_PERSIST, 8, consecutive ticks with an invalid sensor pattern before erro asserts (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  sample enable, one clock wide, from the clock divider chain
- sens_raw  in  3  raw float sensors; bit0 bottom, bit1 middle, bit2 top; 1 = wet
- sw_raw  in  3  raw switches {adb, got, asp}, active-high
- err_clr  in  1  synchronous clear of erro, level-sensitive
- nivel  out  3  encoded level: 000 full, 001 medium, 011 low, 111 critical
- erro  out  1  sensor-fault flag
- sw_db  out  3  debounced {adb, got, asp}
- level_chg  out  1  one-clock pulse when nivel changes value

Behaviour:
- Reset, sampled while reset==0 on a clock edge:
  - nivel=111 (critical, a safe state that inhibits irrigation), erro=0, sw_db=000, level_chg=0.
  - Debounced sensors=000; all counters=0.
  - tick is ignored during reset.
- Debounce, applied independently to each of the 6 inputs:
  - Per-input counter of width $clog2(DEBOUNCE_TICKS+1). It advances only on tick.
  - On a tick where raw != db: increment the counter. If the counter reaches DEBOUNCE_TICKS, flip db and zero the counter.
  - On a tick where raw == db: zero the counter.
  - Non-tick cycles hold all state.
  - Latency: a clean step is reflected on db at the DEBOUNCE_TICKS-th tick after the change.
- Encoding, one clock after the debounced sensors update (registered):
  - Valid patterns: 111->000, 011->001, 001->011, 000->111.
  - Invalid patterns (010, 100, 101, 110): nivel holds its last value.
- Level change: level_chg=1 for exactly one clock whenever the registered nivel differs from its previous value. It never asserts out of reset.
- Fault persistence counter, width $clog2(ERR_PERSIST+1), advances only on tick:
  - Increments while the debounced sensor pattern is invalid, saturating at ERR_PERSIST.
  - Zeroed on any tick with a valid pattern.
  - erro sets on the clock after the counter reaches ERR_PERSIST.
- erro is sticky: cleared only by reset or err_clr==1.
- Simultaneous set condition and err_clr: set wins, so erro stays 1.
- While erro==1, nivel is forced to 111 so the downstream controller takes its safe path.
- Reset mid-debounce discards partial counts.
- Total input-to-nivel latency: DEBOUNCE_TICKS ticks + 1 clock.

Optional Feature:
- Macro: SENSOR_ERR_AUTOCLR_EN.
- Defined: erro also clears automatically after ERR_PERSIST consecutive ticks of a valid debounced pattern. This uses a second recovery counter, zeroed on any invalid tick.
- Undefined: erro clears only via reset or err_clr; no recovery counter exists.

Decomposition:
- Shared package holds:
  - nivel code constants NIVEL_FULL=3'b000, NIVEL_MED=3'b001, NIVEL_LOW=3'b011, NIVEL_CRIT=3'b111
  - sensor-pattern validity function
  - switch index constants SW_ASP=0, SW_GOT=1, SW_ADB=2
- One sub-module, input_debouncer (1-bit, parameter DEBOUNCE_TICKS), instantiated 6 times.

Test Plan:
- Reset with sens_raw=111 -> nivel=111, erro=0, sw_db=000, level_chg=0. After release and 4 ticks + 1 clock, nivel=000 with a single level_chg pulse.
- asp toggles every tick for 10 ticks, then holds 1 -> sw_db[0] stays 0 during toggling and rises exactly on the 4th stable tick.
- Full to empty step: sens_raw 111->011->001->000, each held 6 ticks -> nivel 000->001->011->111, with one level_chg pulse per step.
- sens_raw=101 held 12 ticks -> nivel holds last value until erro sets, 8 ticks after the debounced pattern goes invalid. nivel is then forced to 111. erro stays 1 after sens_raw returns to 011 (macro undefined).
- err_clr pulsed on the same clock the persistence counter reaches ERR_PERSIST -> erro=1 (set wins). err_clr pulsed a later clock with a valid pattern -> erro=0.
- SENSOR_ERR_AUTOCLR_EN defined: after a fault, valid 011 held 8 ticks -> erro returns to 0 and nivel=001.
